// File: rtl/cal_uart_pkg.sv
// rtl/cal_uart_pkg.sv - shared types and constants for the calibration UART receiver
package cal_uart_pkg;

  // Packet start marker, only meaningful while hunting for a packet
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Coefficient kind carried in wr_addr[3]
  localparam logic KIND_OFFSET = 1'b0;
  localparam logic KIND_GAIN   = 1'b1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_SYNC,
    P_ADDR,
    P_HI,
    P_LO,
    P_CSUM
  } pkt_state_t;

  // Packet checksum: XOR of address and both payload bytes
  function automatic logic [7:0] pkt_csum(input logic [7:0] a, input logic [7:0] h,
                                          input logic [7:0] l);
    return a ^ h ^ l;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - line synchronizer and 8N1 byte receiver
module uart_rx_byte
  import cal_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]       bitn_q, bitn_d;
  logic [7:0]       sh_q, sh_d;
  logic             byte_vld_q, byte_vld_d;
  logic [7:0]       byte_q, byte_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_s;

  assign rx_s      = sync2_q;
  assign byte_vld  = byte_vld_q;
  assign byte_data = byte_q;
  assign frame_err = frame_err_q;

  // Byte FSM: mid-bit sampling timed by a down-counter, synchronizer in front
  always_comb begin
    sync1_d     = rx_i;
    sync2_d     = sync1_q;
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    bitn_d      = bitn_q;
    sh_d        = sh_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          bcnt_d  = HALF_BIT;
        end
      end
      RX_START: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else if (rx_s) begin
          // low pulse shorter than half a bit: treat as noise
          state_d = RX_IDLE;
        end else begin
          state_d = RX_DATA;
          bcnt_d  = FULL_BIT;
          bitn_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else begin
          sh_d   = {rx_s, sh_q[7:1]};
          bcnt_d = FULL_BIT;
          if (bitn_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
        end else begin
          // back to idle at mid-stop so a back-to-back start edge is not missed
          state_d = RX_IDLE;
          if (rx_s) begin
            byte_vld_d = 1'b1;
            byte_d     = sh_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // State register; synchronizer presets to the idle-high line level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= RX_IDLE;
      bcnt_q      <= '0;
      bitn_q      <= 3'd0;
      sh_q        <= 8'd0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      bitn_q      <= bitn_d;
      sh_q        <= sh_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: rtl/cal_uart_rx.sv
// rtl/cal_uart_rx.sv - calibration coefficient packet receiver
module cal_uart_rx
  import cal_uart_pkg::*;
#(
  parameter int W           = 16,
  parameter int CLK_HZ      = 12_000_000,
  parameter int BAUD        = 1_000_000,
  parameter int TIMEOUT_BIT = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_i,
  output logic         wr_en,
  output logic [3:0]   wr_addr,
  output logic [W-1:0] wr_data,
  output logic         frame_err,
  output logic         pkt_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TMO_CLKS     = TIMEOUT_BIT * CLKS_PER_BIT;
  localparam int GAP_W        = $clog2(TMO_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TMO_CLKS);

  logic       byte_vld;
  logic [7:0] byte_data;
  logic       byte_ferr;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx_i),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .frame_err(byte_ferr)
  );

  pkt_state_t       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       wr_addr_q, wr_addr_d;
  logic [W-1:0]     wr_data_q, wr_data_d;
  logic             frame_err_q, frame_err_d;
  logic             pkt_err_q, pkt_err_d;
  logic             timeout;
  logic             kind;

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = frame_err_q;
  assign pkt_err   = pkt_err_q;

  assign timeout = (state_q != P_SYNC) && (gap_q == GAP_MAX);
  assign kind    = addr_q[3] ? KIND_GAIN : KIND_OFFSET;

  // Packet FSM and gap timer; frame error beats byte, byte beats timeout
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    pkt_err_d   = 1'b0;

    if (state_q == P_SYNC || byte_vld) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + 1'b1;
    end else begin
      gap_d = gap_q;
    end

    if (byte_ferr) begin
      frame_err_d = 1'b1;
      state_d     = P_SYNC;
    end else if (byte_vld) begin
      case (state_q)
        P_SYNC: if (byte_data == SYNC_BYTE) state_d = P_ADDR;
        P_ADDR: begin
          addr_d  = byte_data;
          state_d = P_HI;
        end
        P_HI: begin
          hi_d    = byte_data;
          state_d = P_LO;
        end
        P_LO: begin
          lo_d    = byte_data;
          state_d = P_CSUM;
        end
        P_CSUM: begin
          state_d = P_SYNC;
          if (byte_data == pkt_csum(addr_q, hi_q, lo_q) && addr_q[7:4] == 4'd0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {kind, addr_q[2:0]};
            wr_data_d = W'({hi_q, lo_q});
          end else begin
            pkt_err_d = 1'b1;
          end
        end
        default: state_d = P_SYNC;
      endcase
    end else if (timeout) begin
      pkt_err_d = 1'b1;
      state_d   = P_SYNC;
    end
  end

  // Packet state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= P_SYNC;
      addr_q      <= 8'd0;
      hi_q        <= 8'd0;
      lo_q        <= 8'd0;
      gap_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      gap_q       <= gap_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_cal_uart_rx.sv
// tb/tb_cal_uart_rx.sv - directed bench for the calibration UART receiver
`timescale 1ns/1ps
module tb_cal_uart_rx;

  localparam int CPB = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        pkt_err;

  int total = 0;
  int bad = 0;
  int n_wr = 0, n_fe = 0, n_pe = 0, n_ovl = 0;
  int s_wr, s_fe, s_pe;

  cal_uart_rx #(
    .W(16), .CLK_HZ(12_000_000), .BAUD(1_000_000), .TIMEOUT_BIT(40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .frame_err(frame_err),
    .pkt_err  (pkt_err)
  );

  always #5 clk = ~clk;

  // strobe counters, sampled just after each active edge
  always @(posedge clk) begin
    #1;
    if (wr_en) n_wr++;
    if (frame_err) n_fe++;
    if (pkt_err) n_pe++;
    if ((wr_en && frame_err) || (wr_en && pkt_err) || (frame_err && pkt_err)) n_ovl++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_v;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                          input logic [7:0] c);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(h, 1'b1);
    send_byte(l, 1'b1);
    send_byte(c, 1'b1);
    tick(30);
  endtask

  task automatic snap();
    s_wr = n_wr;
    s_fe = n_fe;
    s_pe = n_pe;
  endtask

  initial begin
    @(negedge clk);
    // reset
    rst_n = 1'b0;
    rx = 1'b1;
    tick(4);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_pkt_err", 32'(pkt_err), 32'd0);
    rst_n = 1'b1;
    snap();
    tick(1000);
    check("idle_strobes", 32'(n_wr + n_fe + n_pe - s_wr - s_fe - s_pe), 32'd0);

    // good packet
    snap();
    send_pkt(8'h03, 8'h12, 8'h34, 8'h25);
    check("good_wr", 32'(n_wr - s_wr), 32'd1);
    check("good_addr", 32'(wr_addr), 32'h3);
    check("good_data", 32'(wr_data), 32'h1234);
    check("good_errs", 32'(n_fe + n_pe - s_fe - s_pe), 32'd0);

    // bad checksum, then corrected packet
    snap();
    send_pkt(8'h0B, 8'h80, 8'h00, 8'h00);
    check("badcs_pe", 32'(n_pe - s_pe), 32'd1);
    check("badcs_wr", 32'(n_wr - s_wr), 32'd0);
    check("badcs_hold_addr", 32'(wr_addr), 32'h3);
    snap();
    send_pkt(8'h0B, 8'h80, 8'h00, 8'h8B);
    check("gain_wr", 32'(n_wr - s_wr), 32'd1);
    check("gain_addr", 32'(wr_addr), 32'hB);
    check("gain_data", 32'(wr_data), 32'h8000);

    // 3-cycle glitch before the checksum byte must not become a byte
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    tick(20);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(40);
    send_byte(8'h25, 1'b1);
    tick(30);
    check("glitch_wr", 32'(n_wr - s_wr), 32'd1);
    check("glitch_errs", 32'(n_fe + n_pe - s_fe - s_pe), 32'd0);

    // zero stop bit on the HI byte
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h12, 1'b0);
    tick(300);
    check("ferr_fe", 32'(n_fe - s_fe), 32'd1);
    check("ferr_wr", 32'(n_wr - s_wr), 32'd0);
    check("ferr_pe", 32'(n_pe - s_pe), 32'd0);
    snap();
    send_pkt(8'h05, 8'hAB, 8'hCD, 8'h63);
    check("after_ferr_wr", 32'(n_wr - s_wr), 32'd1);
    check("after_ferr_addr", 32'(wr_addr), 32'h5);
    check("after_ferr_data", 32'(wr_data), 32'hABCD);

    // timeout after A5 03
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    tick(41 * CPB + 8);
    check("tmo_pe", 32'(n_pe - s_pe), 32'd1);
    check("tmo_wr", 32'(n_wr - s_wr), 32'd0);
    snap();
    send_pkt(8'h07, 8'h00, 8'h01, 8'h06);
    check("after_tmo_wr", 32'(n_wr - s_wr), 32'd1);
    check("after_tmo_addr", 32'(wr_addr), 32'h7);
    check("after_tmo_data", 32'(wr_data), 32'h0001);

    // payload containing the sync byte
    snap();
    send_pkt(8'h02, 8'hA5, 8'hA5, 8'h02);
    check("a5_wr", 32'(n_wr - s_wr), 32'd1);
    check("a5_addr", 32'(wr_addr), 32'h2);
    check("a5_data", 32'(wr_data), 32'hA5A5);

    // reset mid-DATA of a byte inside a packet
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(4);
    check("midrst_addr", 32'(wr_addr), 32'd0);
    check("midrst_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    tick(300);
    check("midrst_strobes", 32'(n_wr + n_fe + n_pe - s_wr - s_fe - s_pe), 32'd0);
    snap();
    send_pkt(8'h06, 8'h12, 8'h34, 8'h20);
    check("after_rst_wr", 32'(n_wr - s_wr), 32'd1);
    check("after_rst_addr", 32'(wr_addr), 32'h6);
    check("after_rst_data", 32'(wr_data), 32'h1234);

    check("strobe_overlap", 32'(n_ovl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
